// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Define MDU_FAST_MUL_EN for a single-cycle MULT/MULTU path; division stays iterative.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  op_q;
    logic [4:0]  cnt_q;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic [31:0] b_mag;
    logic        neg_q;
    logic        neg_r;
    logic        b_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] mag_prod;
    logic [63:0] prod_s;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef MDU_FAST_MUL_EN
                    state_d = op[1] ? S_RUN : S_FIX;
`else
                    state_d = S_RUN;
`endif
                end
            end
            S_RUN:   if (cnt_q == 5'd31) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Only MULT and DIV (op[0]==0) interpret operands as two's complement
    always_comb begin
        a_neg = ~op[0] & src_a[31];
        b_neg = ~op[0] & src_b[31];
        a_abs = a_neg ? (32'd0 - src_a) : src_a;
        b_abs = b_neg ? (32'd0 - src_b) : src_b;
    end

    // Multiply: w_hi accumulates, w_lo holds the multiplier and collects low product bits.
    // Divide: w_hi is the partial remainder, w_lo shifts the dividend out and the quotient in.
    always_comb begin
        mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, b_mag} : 33'd0);
        div_shift = {w_hi, w_lo[31]};
        div_ge    = div_shift >= {1'b0, b_mag};
        div_diff  = div_shift[31:0] - b_mag;
    end

    always_comb begin
`ifdef MDU_FAST_MUL_EN
        mag_prod = op_q[1] ? {w_hi, w_lo} : ({32'd0, w_lo} * {32'd0, b_mag});
`else
        mag_prod = {w_hi, w_lo};
`endif
        prod_s = neg_q ? (64'd0 - mag_prod) : mag_prod;
        if (op_q[1]) begin
            // Remainder negation also restores a negative dividend on divide-by-zero
            res_hi = neg_r ? (32'd0 - w_hi) : w_hi;
            res_lo = b_zero ? '1 : (neg_q ? (32'd0 - w_lo) : w_lo);
        end else begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            cnt_q  <= '0;
            w_hi   <= '0;
            w_lo   <= '0;
            b_mag  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        cnt_q  <= '0;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= op[1] & a_neg;
                        b_zero <= (src_b == 32'd0);
                        w_hi   <= '0;
                        w_lo   <= a_abs;
                        b_mag  <= b_abs;
                    end else begin
                        if (mthi) hi_q <= src_a;
                        if (mtlo) lo_q <= src_a;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (op_q[1]) begin
                        w_hi <= div_ge ? div_diff : div_shift[31:0];
                        w_lo <= {w_lo[30:0], div_ge};
                    end else begin
                        w_hi <= mul_sum[32:1];
                        w_lo <= {mul_sum[0], w_lo[31:1]};
                    end
                end
                S_FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    cnt_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
